// File: rtl/decode_stage_ctrl_pkg.sv
// Shared definitions for the decode-stage control FSM: state encoding and
// a helper that sizes counters.
package decode_stage_ctrl_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] FETCH  = 2'd0;
  localparam logic [STATE_W-1:0] DECODE = 2'd1;
  localparam logic [STATE_W-1:0] STALL  = 2'd2;
  localparam logic [STATE_W-1:0] FLUSH  = 2'd3;

  // Bits needed to count 0..max_val, never fewer than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/decode_stage_ctrl_if.sv
// Hazard-unit / pipeline-side signal bundle of the decode-stage controller.
interface decode_stage_ctrl_if #(
  parameter int STALL_W = 2,
  parameter int CNT_W   = 16
);

  logic               SetStallDec;
  logic               ClrStallDec;
  logic [STALL_W-1:0] StallLen;
  logic               Flush;
  logic               ExeReady;
  logic               FetchReq;
  logic               DecExeBufferWr;
  logic               DecBubble;
  logic               PCRegWr;
  logic               IsDecStall;
  logic [CNT_W-1:0]   StallCycles;

  modport master (
    output SetStallDec, ClrStallDec, StallLen, Flush, ExeReady,
    input  FetchReq, DecExeBufferWr, DecBubble, PCRegWr, IsDecStall, StallCycles
  );

  modport slave (
    input  SetStallDec, ClrStallDec, StallLen, Flush, ExeReady,
    output FetchReq, DecExeBufferWr, DecBubble, PCRegWr, IsDecStall, StallCycles
  );

endinterface

// File: rtl/decode_stage_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous clear; sticks at all-ones.
module decode_stage_ctrl_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/decode_stage_ctrl.sv
// Decode-stage control FSM: fetch with configurable latency, decode/write,
// programmable stall, back-pressure, flush with bubble, stall-cycle counter.
module decode_stage_ctrl
  import decode_stage_ctrl_pkg::*;
#(
  parameter int FETCH_WAIT = 0,
  parameter int STALL_W    = 2,
  parameter int CNT_W      = 16
) (
  input logic                CLK,
  input logic                RST,
  decode_stage_ctrl_if.slave bus
);

  localparam int FCNT_W = cnt_width(FETCH_WAIT);
  localparam logic [FCNT_W-1:0] FETCH_LAST = FCNT_W'(FETCH_WAIT);

  logic [STATE_W-1:0] state_q, state_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic [STALL_W-1:0] scnt_q, scnt_d;
  logic               decode_wr;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    scnt_d  = scnt_q;
    case (state_q)
      FETCH: begin
        if (fcnt_q == FETCH_LAST) begin
          fcnt_d  = '0;
          state_d = DECODE;
        end else begin
          fcnt_d = fcnt_q + FCNT_W'(1);
        end
      end
      DECODE: begin
        if (bus.ExeReady) begin
          if (bus.SetStallDec) begin
            state_d = STALL;
            scnt_d  = bus.StallLen;
          end else begin
            state_d = FETCH;
          end
        end
      end
      STALL: begin
        if ((scnt_q == '0) || bus.ClrStallDec) begin
          state_d = FETCH;
          scnt_d  = '0;
        end else begin
          scnt_d = scnt_q - STALL_W'(1);
        end
      end
      default: begin
        state_d = FETCH;
        fcnt_d  = '0;
        scnt_d  = '0;
      end
    endcase
    // Flush overrides every state-local decision and discards counter progress.
    if (bus.Flush) begin
      state_d = FLUSH;
      fcnt_d  = '0;
      scnt_d  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      fcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  // A flush in DECODE must not also commit the instruction being decoded.
  assign decode_wr = (state_q == DECODE) && bus.ExeReady && !bus.Flush;

  assign bus.FetchReq       = (state_q == FETCH);
  assign bus.DecExeBufferWr = decode_wr || (state_q == FLUSH);
  assign bus.DecBubble      = (state_q == FLUSH);
  assign bus.PCRegWr        = decode_wr;
  assign bus.IsDecStall     = (state_q == STALL);

  decode_stage_ctrl_sat_counter #(
    .W(CNT_W)
  ) u_stall_cycles (
    .clk  (CLK),
    .rst  (RST),
    .en   (state_q == STALL),
    .clr  (1'b0),
    .count(bus.StallCycles)
  );

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Randomised bench: two controller instances (single-cycle and 3-cycle fetch)
// checked every cycle against a behavioural phase/remaining-cycles model.
module tb_decode_stage_ctrl;

  localparam int P_FETCH  = 0;
  localparam int P_DECODE = 1;
  localparam int P_STALL  = 2;
  localparam int P_FLUSH  = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       set_stall = 1'b0;
  logic       clr_stall = 1'b0;
  logic       flush = 1'b0;
  logic       exe_ready = 1'b0;
  logic [1:0] stall_len = 2'd0;

  int checks = 0;
  int failures = 0;

  int phase  [2];
  int left   [2];
  int stalls [2];
  int fwait  [2] = '{0, 2};
  int cmax   [2] = '{15, 255};

  decode_stage_ctrl_if #(.STALL_W(2), .CNT_W(4)) bus_a ();
  decode_stage_ctrl_if #(.STALL_W(2), .CNT_W(8)) bus_b ();

  assign bus_a.SetStallDec = set_stall;
  assign bus_a.ClrStallDec = clr_stall;
  assign bus_a.StallLen    = stall_len;
  assign bus_a.Flush       = flush;
  assign bus_a.ExeReady    = exe_ready;
  assign bus_b.SetStallDec = set_stall;
  assign bus_b.ClrStallDec = clr_stall;
  assign bus_b.StallLen    = stall_len;
  assign bus_b.Flush       = flush;
  assign bus_b.ExeReady    = exe_ready;

  decode_stage_ctrl #(.FETCH_WAIT(0), .STALL_W(2), .CNT_W(4)) dut_a (
    .CLK(CLK), .RST(RST), .bus(bus_a)
  );

  decode_stage_ctrl #(.FETCH_WAIT(2), .STALL_W(2), .CNT_W(8)) dut_b (
    .CLK(CLK), .RST(RST), .bus(bus_b)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      phase[i]  = P_FETCH;
      left[i]   = fwait[i];
      stalls[i] = 0;
    end
  endtask

  // Moves the model across one rising edge using the inputs currently driven.
  task automatic modelAdvance();
    for (int i = 0; i < 2; i++) begin
      if (RST) begin
        phase[i]  = P_FETCH;
        left[i]   = fwait[i];
        stalls[i] = 0;
      end else begin
        if (phase[i] == P_STALL && stalls[i] < cmax[i]) stalls[i]++;
        if (flush) begin
          phase[i] = P_FLUSH;
        end else begin
          case (phase[i])
            P_FETCH: begin
              if (left[i] == 0) phase[i] = P_DECODE;
              else left[i]--;
            end
            P_DECODE: begin
              if (exe_ready) begin
                if (set_stall) begin
                  phase[i] = P_STALL;
                  left[i]  = int'(stall_len);
                end else begin
                  phase[i] = P_FETCH;
                  left[i]  = fwait[i];
                end
              end
            end
            P_STALL: begin
              if (left[i] == 0 || clr_stall) begin
                phase[i] = P_FETCH;
                left[i]  = fwait[i];
              end else begin
                left[i]--;
              end
            end
            default: begin
              phase[i] = P_FETCH;
              left[i]  = fwait[i];
            end
          endcase
        end
      end
    end
  endtask

  task automatic checkDut(input int i, input logic fr, input logic wr, input logic bub,
                          input logic pc, input logic st, input logic [31:0] cyc);
    logic commit;
    commit = (phase[i] == P_DECODE) && exe_ready && !flush;
    checkOutput($sformatf("dut%0d_FetchReq", i), 32'(fr), 32'(phase[i] == P_FETCH));
    checkOutput($sformatf("dut%0d_DecExeBufferWr", i), 32'(wr), 32'(commit || phase[i] == P_FLUSH));
    checkOutput($sformatf("dut%0d_DecBubble", i), 32'(bub), 32'(phase[i] == P_FLUSH));
    checkOutput($sformatf("dut%0d_PCRegWr", i), 32'(pc), 32'(commit));
    checkOutput($sformatf("dut%0d_IsDecStall", i), 32'(st), 32'(phase[i] == P_STALL));
    checkOutput($sformatf("dut%0d_StallCycles", i), cyc, 32'(stalls[i]));
  endtask

  task automatic applyStimulus(input logic rst, input logic set, input logic clr,
                               input logic fl, input logic exe, input logic [1:0] len);
    @(negedge CLK);
    RST       = rst;
    set_stall = set;
    clr_stall = clr;
    flush     = fl;
    exe_ready = exe;
    stall_len = len;
    #1;
    checkDut(0, bus_a.FetchReq, bus_a.DecExeBufferWr, bus_a.DecBubble,
             bus_a.PCRegWr, bus_a.IsDecStall, 32'(bus_a.StallCycles));
    checkDut(1, bus_b.FetchReq, bus_b.DecExeBufferWr, bus_b.DecBubble,
             bus_b.PCRegWr, bus_b.IsDecStall, 32'(bus_b.StallCycles));
    modelAdvance();
  endtask

  initial begin
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    modelReset();

    for (int n = 0; n < 20; n++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    end

    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 11) == 0),
                    ($urandom_range(0, 3) != 0),
                    2'($urandom_range(0, 3)));
    end

    for (int n = 0; n < 300; n++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 3)));
    end

    for (int n = 0; n < 3; n++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    end
    for (int n = 0; n < 10; n++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage_ctrl.md
Name: decode_stage_ctrl

Overview:
- Parametrised control FSM for the decode stage of the pipelined microprocessor.
- Sequences instruction fetch (configurable memory latency), decode with write into the DEC/EXE buffer, and PC update.
- Adds programmable-length stall, early stall release, downstream back-pressure, pipeline flush with bubble insertion, and a saturating stall-cycle counter.
- Sits between the hazard unit (stall/flush requests) and the DEC/EXE buffer, PC register and instruction memory.

Parameters:
- FETCH_WAIT, 0, extra cycles the FETCH state holds for instruction-memory latency (0 = single-cycle fetch).
- STALL_W, 2, width of StallLen and the stall down-counter.
- CNT_W, 16, width of the StallCycles performance counter.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- SetStallDec  in  1  request a stall; sampled only in DECODE.
- ClrStallDec  in  1  release a stall early; sampled only in STALL.
- StallLen  in  STALL_W  stall length minus one; captured on STALL entry.
- Flush  in  1  discard the in-flight instruction and insert a bubble.
- ExeReady  in  1  execute stage can accept a DEC/EXE write.
- FetchReq  out  1  instruction-memory read enable.
- DecExeBufferWr  out  1  write enable for the DEC/EXE buffer.
- DecBubble  out  1  with DecExeBufferWr, selects a NOP into the buffer.
- PCRegWr  out  1  PC register write enable.
- IsDecStall  out  1  FSM is in STALL.
- StallCycles  out  CNT_W  saturating count of cycles spent in STALL.

Behaviour:
- States (2-bit encoding):
  - FETCH=0
  - DECODE=1
  - STALL=2
  - FLUSH=3
- Reset: state FETCH, fetch counter 0, stall counter 0, StallCycles 0. All outputs 0 except FetchReq=1, which is decoded from FETCH.
- Global priority: RST > Flush > state-local conditions.
- Flush in any state: next state FLUSH.
- FETCH:
  - FetchReq=1; all other strobes 0.
  - Fetch counter increments each cycle.
  - At counter==FETCH_WAIT: counter clears and next state is DECODE.
  - FETCH therefore lasts FETCH_WAIT+1 cycles.
- DECODE with ExeReady=1:
  - DecExeBufferWr=1 and PCRegWr=1 in the same cycle.
  - Next state is STALL if SetStallDec=1, else FETCH.
- DECODE with ExeReady=0:
  - DecExeBufferWr=0 and PCRegWr=0; remain in DECODE (hold).
  - SetStallDec is ignored while holding.
- DECODE Mealy rule: DecExeBufferWr and PCRegWr are gated combinationally by ExeReady; all other outputs are Moore.
- STALL:
  - IsDecStall=1; all strobes 0.
  - On entry the stall counter loads StallLen, then decrements each cycle in STALL.
  - Exit to FETCH when counter==0 or ClrStallDec=1.
  - STALL lasts StallLen+1 cycles; StallLen=0 gives exactly 1 cycle.
  - The counter never wraps below 0.
- FLUSH:
  - Lasts one cycle.
  - DecExeBufferWr=1, DecBubble=1, PCRegWr=0, regardless of ExeReady (a bubble always overwrites the buffer).
  - Next state FETCH, or FLUSH again if Flush is still high.
  - Fetch and stall counters clear.
- StallCycles: increments by 1 each cycle IsDecStall=1; saturates at all-ones; cleared only by RST.
- Simultaneous events:
  - Flush with SetStallDec in DECODE: FLUSH wins and no buffer write occurs from DECODE.
  - ClrStallDec on the STALL entry cycle: ignored, because it is sampled only while in STALL.
- Reset mid-operation: any state returns to FETCH next edge; all counters clear.

Decomposition:
- Shared package holds the state encoding constants (FETCH, DECODE, STALL, FLUSH) and the 2-bit state width.
- FETCH_WAIT counter width: $clog2(FETCH_WAIT+1), minimum 1 bit.
- Natural sub-module: sat_counter (parametrised width, enable, synchronous clear, saturate), used for StallCycles.
- Fetch and stall counters stay inline.

Test Plan:
- RST=1 for 2 cycles, then FETCH_WAIT=0, ExeReady=1, no requests -> FetchReq/DecExeBufferWr alternate 1,0 every cycle; PCRegWr=1 on every second cycle; StallCycles=0.
- FETCH_WAIT=2 -> FetchReq high 3 consecutive cycles, then 1 DECODE cycle with both write strobes high; repeats with period 4.
- SetStallDec=1 in DECODE with StallLen=3 -> IsDecStall high exactly 4 cycles, then FETCH; StallCycles=4. Repeat with StallLen=0 -> 1 cycle; StallCycles=5.
- StallLen=3 and ClrStallDec pulsed on the 2nd STALL cycle -> IsDecStall high exactly 2 cycles; next state FETCH.
- ExeReady=0 for 3 cycles in DECODE, then 1 -> no write strobes for 3 cycles, then one write; SetStallDec asserted during the hold is ignored.
- Flush asserted during STALL (counter=2) and simultaneously with SetStallDec in DECODE -> next cycle DecExeBufferWr=1, DecBubble=1, PCRegWr=0, IsDecStall=0, then FETCH.
- Drive 2^CNT_W+5 stall cycles with CNT_W=4 -> StallCycles holds 15.
